mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Main control sequencer for the multi-cycle build of the MIPS core.
- Replaces the single-cycle combinational decoder with an FSM that drives the shared ALU, register file, PC and a single unified instruction/data memory.
- Adds a memory ready handshake, an illegal-opcode halt, and a retired-instruction counter.
- Instantiated once in the top level. Opcode and funct come from the instruction register; zero comes from the ALU.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction register [31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  unified memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- pc_en  out  1  pc_write | (pc_write_cond & zero)
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_dst  out  1  write register: 0=rt, 1=rd
- mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  ALU A: 0=PC, 1=rs data
- alu_src_b  out  2  ALU B: 00=rt data, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  to ALU control: 00 add, 01 sub, 10 funct
- pc_source  out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current state encoding (debug)
- halted  out  1  FSM in HALT
- retired  out  CNT_W  instructions completed since reset

Behaviour:
- Reset (rst=1 at a rising edge):
  - state<=FETCH(0), retired<=0.
  - While rst=1, all enables (pc_write, pc_write_cond, pc_en, mem_read, mem_write, ir_write, reg_write) are forced 0.
  - Reset mid-instruction abandons it with no write and no count.
- Outputs are Moore decodes of state, except the FETCH enables, which also depend on mem_ready. Any output not listed for a state is 0.
- States, outputs and transitions:
  - FETCH(0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Stay while mem_ready=0; else ->DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x00 -> R_EXEC
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> I_EXEC
    - any other -> HALT
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Next: opcode 0x23 -> MEM_READ, else -> MEM_WRITE.
  - MEM_READ(3): mem_read=1, iord=1. Hold until mem_ready, then -> MEM_WB.
  - MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH.
  - MEM_WRITE(5): mem_write=1, iord=1, held every waiting cycle; memory commits only in the mem_ready cycle. Hold until mem_ready, then -> FETCH.
  - R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. -> R_WB.
  - R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. -> FETCH.
  - JUMP(9): pc_write=1, pc_source=10. -> FETCH.
  - I_EXEC(10): alu_src_a=1, alu_src_b=10, alu_op=00. -> I_WB.
  - I_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
  - HALT(12): halted=1, all enables 0. Exit only by rst.
  - Encodings 13-15 are unreachable; if entered, go to HALT.
- Retired counter: retired increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE (with mem_ready), R_WB, BRANCH, JUMP or I_WB.
  - It does not increment on reset, on entering HALT, or while waiting.
  - It wraps from 2^CNT_W-1 to 0.
- Latency with mem_ready tied high, in cycles:
  - R-type 4, addi 4, beq 3, j 3, sw 4, lw 5.
  - Each low cycle of mem_ready during FETCH, MEM_READ or MEM_WRITE adds one cycle.
- A branch is taken when pc_en=1 in BRANCH; zero is sampled only in that state.

Test Plan:
- Reset then R-type: assert rst 2 cycles, mem_ready=1, opcode=0x00 -> state sequence 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7. retired=1 after the return to 0.
- lw with wait states: opcode=0x23, mem_ready low 3 cycles in MEM_READ -> state sequence 0,1,2,3,3,3,3,4,0. mem_read=1 and iord=1 throughout state 3. retired increments once.
- sw, plus FETCH stall: opcode=0x2B, mem_ready low 2 cycles in FETCH:
  - FETCH: ir_write and pc_write stay 0 until the ready cycle, then pulse for exactly 1 cycle.
  - MEM_WRITE: mem_write=1 for every cycle of state 5.
- beq: opcode=0x04 with zero=1 -> pc_en=1 and pc_source=01 in state 8. Repeat with zero=0 -> pc_en=0. Both runs give total 3 cycles and retired +1.
- Illegal opcode and reset mid-instruction:
  - opcode=0x3F -> state 12 and halted=1; stays there 10 cycles with all enables 0 and retired unchanged. rst -> state 0, halted=0, retired=0.
  - rst asserted in state 6 -> next state 0, no reg_write pulse.
- Counter wrap: run with CNT_W=4 for 17 addi (0x08) instructions -> retired reads 15, then 0, then 1. Each addi takes states 0,1,10,11.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control sequencer.
// Drives ALU, register file, PC and the unified instruction/data memory,
// with a memory ready handshake, an illegal-opcode halt and a retired count.
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;

  // Raw Moore enables before reset gating
  logic w_pc_write;
  logic w_pc_write_cond;
  logic w_mem_read;
  logic w_mem_write;
  logic w_ir_write;
  logic w_reg_write;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Next-state, retire strobe and Moore output decode
  always_comb begin
    w_next          = r_state;
    w_retire        = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    iord            = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_op          = 2'b00;
    pc_source       = 2'b00;
    halted          = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        alu_src_b  = 2'b01;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_RTYPE:     w_next = S_R_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_I_EXEC;
          default:      w_next = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        w_mem_read = 1'b1;
        iord       = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_MEM_WRITE: begin
        w_mem_write = 1'b1;
        iord        = 1'b1;
        if (mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_op          = 2'b01;
        w_pc_write_cond = 1'b1;
        pc_source       = 2'b01;
        w_next          = S_FETCH;
        w_retire        = 1'b1;
      end
      S_JUMP: begin
        w_pc_write = 1'b1;
        pc_source  = 2'b10;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_I_WB;
      end
      S_I_WB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: begin
        w_next = S_HALT;
      end
    endcase
  end

  // Enables are suppressed combinationally while reset is held so an
  // abandoned instruction cannot write anything in its reset cycle.
  assign pc_write      = w_pc_write & ~rst;
  assign pc_write_cond = w_pc_write_cond & ~rst;
  assign pc_en         = (w_pc_write | (w_pc_write_cond & zero)) & ~rst;
  assign mem_read      = w_mem_read & ~rst;
  assign mem_write     = w_mem_write & ~rst;
  assign ir_write      = w_ir_write & ~rst;
  assign reg_write     = w_reg_write & ~rst;
  assign state         = r_state;
  assign retired       = r_retired;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the driver plans each
// instruction as a list of cycles, pushes the expected outputs per cycle,
// and a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write;
  logic             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [3:0]       state;
  logic             halted;
  logic [CNT_W-1:0] retired;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .state(state),
    .halted(halted), .retired(retired)
  );

  typedef struct {
    int               st;
    logic [17:0]      ctl;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t             q[$];
  int               checks   = 0;
  int               failures = 0;
  int               cycle_no = 0;
  logic [CNT_W-1:0] m_count  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output table of each state, written straight from the state descriptions
  function automatic logic [17:0] exp_ctl(input int st, input bit mr, input bit z, input bit r);
    logic pw, pwc, pe, io, mrd, mwr, irw, rd, m2r, rw, sa, h;
    logic [1:0] sb, aop, ps;
    {pw, pwc, pe, io, mrd, mwr, irw, rd, m2r, rw, sa, h} = '0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mrd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; io = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: h = 1;
      default: h = 1;
    endcase
    pe = pw | (pwc & z);
    if (r) {pw, pwc, pe, mrd, mwr, irw, rw} = '0;
    return {pw, pwc, pe, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, aop, ps, h};
  endfunction

  // Drive one cycle and record what the DUT must show during it
  task automatic cyc(input int st, input bit mr, input bit z, input bit r, input logic [5:0] op);
    exp_t e;
    mem_ready = mr; zero = z; rst = r; opcode = op;
    e.st  = st;
    e.ctl = exp_ctl(st, mr, z, r);
    e.ret = m_count;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Plan one instruction: fw FETCH wait cycles, mw memory wait cycles,
  // branch zero flag z, and optional reset at cycle index rst_at.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit z, input int rst_at);
    int sts[$];
    bit rdy[$];
    bit legal;
    legal = 1'b1;
    for (int i = 0; i < fw; i++) begin sts.push_back(0); rdy.push_back(1'b0); end
    sts.push_back(0); rdy.push_back(1'b1);
    sts.push_back(1); rdy.push_back(1'($urandom));
    case (op)
      6'h23: begin
        sts.push_back(2); rdy.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin sts.push_back(3); rdy.push_back(1'b0); end
        sts.push_back(3); rdy.push_back(1'b1);
        sts.push_back(4); rdy.push_back(1'($urandom));
      end
      6'h2B: begin
        sts.push_back(2); rdy.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin sts.push_back(5); rdy.push_back(1'b0); end
        sts.push_back(5); rdy.push_back(1'b1);
      end
      6'h00: begin sts.push_back(6); rdy.push_back(1'($urandom)); sts.push_back(7); rdy.push_back(1'($urandom)); end
      6'h04: begin sts.push_back(8); rdy.push_back(1'($urandom)); end
      6'h02: begin sts.push_back(9); rdy.push_back(1'($urandom)); end
      6'h08: begin sts.push_back(10); rdy.push_back(1'($urandom)); sts.push_back(11); rdy.push_back(1'($urandom)); end
      default: begin
        legal = 1'b0;
        for (int i = 0; i < 10; i++) begin sts.push_back(12); rdy.push_back(1'($urandom)); end
      end
    endcase
    for (int i = 0; i < sts.size(); i++) begin
      logic [5:0] o;
      bit zz;
      o  = (sts[i] == 0) ? 6'($urandom) : op;
      zz = (sts[i] == 8) ? z : 1'($urandom);
      if (i == rst_at) begin
        cyc(sts[i], rdy[i], zz, 1'b1, o);
        m_count = '0;
        return;
      end
      cyc(sts[i], rdy[i], zz, 1'b0, o);
    end
    if (legal) begin
      m_count = m_count + CNT_W'(1);
    end else begin
      cyc(12, 1'($urandom), 1'($urandom), 1'b1, op);
      m_count = '0;
    end
  endtask

  // Monitor: compare every recorded cycle at the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [17:0] act;
      e   = q.pop_front();
      act = {pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, halted};
      checks++;
      if (state !== 4'(e.st)) begin
        failures++;
        $display("FAIL state cyc=%0d got=%0d exp=%0d", cycle_no, state, e.st);
      end
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL ctl cyc=%0d st=%0d got=%b exp=%b", cycle_no, e.st, act, e.ctl);
      end
      checks++;
      if (retired !== e.ret) begin
        failures++;
        $display("FAIL retired cyc=%0d got=%0d exp=%0d", cycle_no, retired, e.ret);
      end
    end
    cycle_no++;
  end

  logic [5:0] legal_ops [6];

  initial begin
    legal_ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
    rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    cyc(0, 1'b1, 1'b0, 1'b1, 6'h00);
    cyc(0, 1'b1, 1'b0, 1'b1, 6'h00);

    // Directed sequences
    run_instr(6'h00, 0, 0, 1'b0, -1);   // R-type
    run_instr(6'h23, 0, 3, 1'b0, -1);   // lw, 3 wait cycles
    run_instr(6'h2B, 2, 1, 1'b0, -1);   // sw, 2 fetch stalls
    run_instr(6'h04, 0, 0, 1'b1, -1);   // beq taken
    run_instr(6'h04, 0, 0, 1'b0, -1);   // beq not taken
    run_instr(6'h02, 0, 0, 1'b0, -1);   // j
    run_instr(6'h08, 1, 0, 1'b0, -1);   // addi
    run_instr(6'h3F, 0, 0, 1'b0, -1);   // illegal -> HALT, then reset
    run_instr(6'h00, 0, 0, 1'b0, 2);    // reset during R_EXEC
    run_instr(6'h00, 0, 0, 1'b0, 3);    // reset during R_WB, no write
    for (int i = 0; i < 17; i++) run_instr(6'h08, 0, 0, 1'b0, -1); // counter wrap

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      logic [5:0] op;
      int ra;
      op = ($urandom_range(0, 11) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
      ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom), ra);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
